// File: rtl/pipeline_multiplication.sv
// pipeline_multiplication: rebuilds dividend = quotient * divisor + remainder
// with a shift-add pipeline of one stage per quotient bit, valid-only handshake.
module pipeline_multiplication #(
    parameter int QUOTIENT_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [QUOTIENT_WIDTH-1:0]               quotient_i,
    input  logic [DIVISOR_WIDTH-1:0]                divisor_i,
    input  logic [DIVISOR_WIDTH-1:0]                reminder_i,
    input  logic                                    valid_i,
    output logic [QUOTIENT_WIDTH+DIVISOR_WIDTH-1:0] dividend_o,
    output logic                                    rem_err_o,
    output logic                                    valid_o
);
    localparam int Q = QUOTIENT_WIDTH;
    localparam int W = QUOTIENT_WIDTH + DIVISOR_WIDTH;

    logic [Q-1:0] vld_q, en, err_q, err_d;
    logic [W-1:0] acc_q [Q];
    logic [W-1:0] acc_d [Q];
    logic [W-1:0] div_q [Q];
    logic [W-1:0] div_d [Q];
    logic [Q-1:0] quo_q [Q];
    logic [Q-1:0] quo_d [Q];

    // Stage k holds divisor << k and the quotient bits above k still to consume.
    always_comb begin
        en       = {vld_q[Q-2:0], valid_i};
        acc_d[0] = W'(reminder_i) + (quotient_i[0] ? W'(divisor_i) : '0);
        div_d[0] = W'(divisor_i);
        quo_d[0] = quotient_i >> 1;
        err_d[0] = reminder_i >= divisor_i;
        for (int k = 1; k < Q; k++) begin
            acc_d[k] = acc_q[k-1] + (quo_q[k-1][0] ? (div_q[k-1] << 1) : '0);
            div_d[k] = div_q[k-1] << 1;
            quo_d[k] = quo_q[k-1] >> 1;
            err_d[k] = err_q[k-1];
        end
    end

    // Data registers only load behind a valid item, so idle inputs never leak out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int k = 0; k < Q; k++) begin
                acc_q[k] <= '0;
                div_q[k] <= '0;
                quo_q[k] <= '0;
            end
        end else begin
            vld_q <= en;
            for (int k = 0; k < Q; k++) begin
                if (en[k]) begin
                    acc_q[k] <= acc_d[k];
                    div_q[k] <= div_d[k];
                    quo_q[k] <= quo_d[k];
                    err_q[k] <= err_d[k];
                end
            end
        end
    end

    assign dividend_o = acc_q[Q-1];
    assign rem_err_o  = err_q[Q-1];
    assign valid_o    = vld_q[Q-1];
endmodule

// File: tb/tb_pipeline_multiplication.sv
// tb_pipeline_multiplication: scoreboard bench checking value, order and exact
// latency of every result, plus reset clearing and bubble preservation.
module tb_pipeline_multiplication;
    localparam int Q = 8;
    localparam int D = 8;
    localparam int W = Q + D;

    typedef struct {
        int           due;
        logic [W-1:0] dv;
        logic         err;
    } exp_t;

    logic         clk_i = 0;
    logic         rst_i = 1;
    logic [Q-1:0] quotient_i = '0;
    logic [D-1:0] divisor_i = '0;
    logic [D-1:0] reminder_i = '0;
    logic         valid_i = 0;
    logic [W-1:0] dividend_o;
    logic         rem_err_o;
    logic         valid_o;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];

    pipeline_multiplication #(.QUOTIENT_WIDTH(Q), .DIVISOR_WIDTH(D)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .quotient_i (quotient_i),
        .divisor_i  (divisor_i),
        .reminder_i (reminder_i),
        .valid_i    (valid_i),
        .dividend_o (dividend_o),
        .rem_err_o  (rem_err_o),
        .valid_o    (valid_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Sampled at edge cyc+1, visible after edge cyc+Q.
    task automatic drive(input logic [Q-1:0] q, input logic [D-1:0] d, input logic [D-1:0] r,
                         input logic [W-1:0] exp, input logic err);
        valid_i    = 1;
        quotient_i = q;
        divisor_i  = d;
        reminder_i = r;
        if (!rst_i) sb.push_back('{cyc + Q, exp, err});
        @(posedge clk_i);
        #1;
        valid_i = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_i    = 0;
            quotient_i = Q'($urandom);
            divisor_i  = D'($urandom);
            reminder_i = D'($urandom);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic rand_item();
        logic [Q-1:0] q;
        logic [D-1:0] d, r;
        q = Q'($urandom);
        d = D'($urandom);
        r = D'($urandom);
        drive(q, d, r, W'(q) * W'(d) + W'(r), r >= d);
    endtask

    always @(negedge clk_i) begin
        if (valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(valid_o), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", cyc, e.due);
                check("dividend", 32'(dividend_o), 32'(e.dv));
                check("rem_err", 32'(rem_err_o), 32'(e.err));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("missing_valid", 32'(valid_o), 1);
            void'(sb.pop_front());
        end
    end

    initial begin
        int gaps[6] = '{1, 0, 0, 1, 0, 1};
        int dv, dd, w;
        idle(2);
        rst_i = 0;
        check("rst_valid", 32'(valid_o), 0);
        check("rst_dividend", 32'(dividend_o), 0);
        check("rst_err", 32'(rem_err_o), 0);
        idle(10);
        check("idle_dividend", 32'(dividend_o), 0);
        check("idle_err", 32'(rem_err_o), 0);

        drive(17, 12, 5, 209, 0);
        idle(10);
        drive(255, 255, 254, 65279, 0);
        drive(0, 200, 9, 9, 0);
        drive(3, 0, 7, 7, 1);
        drive(2, 5, 5, 15, 1);
        idle(10);

        for (int i = 1; i <= 8; i++) drive(Q'(i), D'(i + 1), D'(i), W'(i * (i + 1) + i), 0);
        foreach (gaps[i]) if (gaps[i] == 1) rand_item(); else idle(1);
        idle(10);

        for (int i = 0; i < 4; i++) rand_item();
        rst_i = 1;
        drive(99, 1, 1, 0, 0);
        rst_i = 0;
        sb.delete();
        check("midrst_valid", 32'(valid_o), 0);
        check("midrst_dividend", 32'(dividend_o), 0);
        drive(10, 10, 3, 103, 0);
        idle(10);

        for (int i = 0; i < 100; i++) begin
            dd = $urandom_range(1, 255);
            dv = $urandom_range(0, 256 * dd - 1);
            drive(Q'(dv / dd), D'(dd), D'(dv % dd), W'(dv), 0);
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        w = 0;
        while (sb.size() > 0 && w < 40) begin
            idle(1);
            w++;
        end
        check("drain", sb.size(), 0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
